// File: rtl/ycr1_pipe_mprf_wrctl.sv
// MPRF write-port arbiter between EXU writeback and LSU load return, plus the
// pending-load scoreboard that stalls dependent reads and WAW writes.
module ycr1_pipe_mprf_wrctl #(
  parameter int AWIDTH    = 5,
  parameter int XLEN      = 32,
  parameter int MAX_OUTST = 2,
  parameter int MAX_WAIT  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exu_wr_req_i,
  input  logic [AWIDTH-1:0] exu_wr_addr_i,
  input  logic [XLEN-1:0]   exu_wr_data_i,
  output logic              exu_wr_rdy_o,
  input  logic              lsu_issue_vld_i,
  input  logic [AWIDTH-1:0] lsu_issue_addr_i,
  output logic              lsu_issue_rdy_o,
  input  logic              lsu_wr_vld_i,
  input  logic [AWIDTH-1:0] lsu_wr_addr_i,
  input  logic [XLEN-1:0]   lsu_wr_data_i,
  output logic              lsu_wr_rdy_o,
  input  logic [AWIDTH-1:0] rs1_addr_i,
  input  logic [AWIDTH-1:0] rs2_addr_i,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  output logic              mprf_w_req_o,
  output logic [AWIDTH-1:0] mprf_rd_addr_o,
  output logic [XLEN-1:0]   mprf_rd_data_o,
  output logic [2:0]        outst_cnt_o
);

  localparam int NREG = 1 << AWIDTH;

  logic [NREG-1:0]   busy_q, busy_d;
  logic [2:0]        outst_q, outst_d;
  logic [3:0]        wait_q, wait_d;

  logic              exu_busy_s;
  logic              exu_elig_s;
  logic              lsu_prio_s;
  logic              exu_gnt_s;
  logic              lsu_gnt_s;
  logic              issue_ok_s;
  logic              issue_acc_s;
  logic [AWIDTH-1:0] wr_addr_s;
  logic [XLEN-1:0]   wr_data_s;

  assign exu_busy_s = (exu_wr_addr_i != '0) & busy_q[exu_wr_addr_i];
  assign exu_elig_s = exu_wr_req_i & ~exu_busy_s;
  assign lsu_prio_s = (wait_q == 4'(MAX_WAIT));

  // Grant selection; a starved LSU only takes priority while it is still requesting
  always_comb begin
    exu_gnt_s = 1'b0;
    lsu_gnt_s = 1'b0;
    if (!rst_n) begin
      exu_gnt_s = 1'b0;
      lsu_gnt_s = 1'b0;
    end else if (lsu_prio_s && lsu_wr_vld_i) begin
      lsu_gnt_s = 1'b1;
    end else begin
      exu_gnt_s = exu_elig_s;
      lsu_gnt_s = lsu_wr_vld_i & ~exu_elig_s;
    end
  end

  // Write-port data mux
  always_comb begin
    wr_addr_s = '0;
    wr_data_s = '0;
    if (exu_gnt_s) begin
      wr_addr_s = exu_wr_addr_i;
      wr_data_s = exu_wr_data_i;
    end else if (lsu_gnt_s) begin
      wr_addr_s = lsu_wr_addr_i;
      wr_data_s = lsu_wr_data_i;
    end else begin
      wr_addr_s = '0;
      wr_data_s = '0;
    end
  end

  assign issue_ok_s  = rst_n & (outst_q < 3'(MAX_OUTST))
                     & ~((lsu_issue_addr_i != '0) & busy_q[lsu_issue_addr_i]);
  assign issue_acc_s = lsu_issue_vld_i & issue_ok_s;

  assign exu_wr_rdy_o    = exu_gnt_s;
  assign lsu_wr_rdy_o    = lsu_gnt_s;
  assign lsu_issue_rdy_o = issue_ok_s;
  assign mprf_w_req_o    = (exu_gnt_s | lsu_gnt_s) & (wr_addr_s != '0);
  assign mprf_rd_addr_o  = wr_addr_s;
  assign mprf_rd_data_o  = wr_data_s;
  assign rs1_busy_o      = (rs1_addr_i != '0) & busy_q[rs1_addr_i];
  assign rs2_busy_o      = (rs2_addr_i != '0) & busy_q[rs2_addr_i];
  assign outst_cnt_o     = outst_q;

  // Scoreboard and counter next state; clear before set so a return to a
  // non-busy rd cannot wipe a same-cycle issue
  always_comb begin
    busy_d = busy_q;
    if (lsu_gnt_s) begin
      busy_d[lsu_wr_addr_i] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (issue_acc_s && (lsu_issue_addr_i != '0)) begin
      busy_d[lsu_issue_addr_i] = 1'b1;
    end else begin
      busy_d[0] = 1'b0;
    end
    busy_d[0] = 1'b0;

    case ({issue_acc_s, lsu_gnt_s})
      2'b10:   outst_d = outst_q + 3'd1;
      2'b01:   outst_d = (outst_q != 3'd0) ? (outst_q - 3'd1) : 3'd0;
      default: outst_d = outst_q;
    endcase

    if (!lsu_wr_vld_i || lsu_gnt_s) begin
      wait_d = 4'd0;
    end else if (wait_q < 4'(MAX_WAIT)) begin
      wait_d = wait_q + 4'd1;
    end else begin
      wait_d = wait_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      outst_q <= 3'd0;
      wait_q  <= 4'd0;
    end else begin
      busy_q  <= busy_d;
      outst_q <= outst_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: tb/tb_ycr1_pipe_mprf_wrctl.sv
// Directed bench for the MPRF write controller: reset, load round trip,
// starvation bound, WAW stall, credit limit and x0 handling.
module tb_ycr1_pipe_mprf_wrctl;

  logic        clk;
  logic        rst_n;
  logic        exu_wr_req_i;
  logic [4:0]  exu_wr_addr_i;
  logic [31:0] exu_wr_data_i;
  logic        exu_wr_rdy_o;
  logic        lsu_issue_vld_i;
  logic [4:0]  lsu_issue_addr_i;
  logic        lsu_issue_rdy_o;
  logic        lsu_wr_vld_i;
  logic [4:0]  lsu_wr_addr_i;
  logic [31:0] lsu_wr_data_i;
  logic        lsu_wr_rdy_o;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic        rs1_busy_o;
  logic        rs2_busy_o;
  logic        mprf_w_req_o;
  logic [4:0]  mprf_rd_addr_o;
  logic [31:0] mprf_rd_data_o;
  logic [2:0]  outst_cnt_o;

  int errs   = 0;
  int checks = 0;

  ycr1_pipe_mprf_wrctl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .exu_wr_req_i     (exu_wr_req_i),
    .exu_wr_addr_i    (exu_wr_addr_i),
    .exu_wr_data_i    (exu_wr_data_i),
    .exu_wr_rdy_o     (exu_wr_rdy_o),
    .lsu_issue_vld_i  (lsu_issue_vld_i),
    .lsu_issue_addr_i (lsu_issue_addr_i),
    .lsu_issue_rdy_o  (lsu_issue_rdy_o),
    .lsu_wr_vld_i     (lsu_wr_vld_i),
    .lsu_wr_addr_i    (lsu_wr_addr_i),
    .lsu_wr_data_i    (lsu_wr_data_i),
    .lsu_wr_rdy_o     (lsu_wr_rdy_o),
    .rs1_addr_i       (rs1_addr_i),
    .rs2_addr_i       (rs2_addr_i),
    .rs1_busy_o       (rs1_busy_o),
    .rs2_busy_o       (rs2_busy_o),
    .mprf_w_req_o     (mprf_w_req_o),
    .mprf_rd_addr_o   (mprf_rd_addr_o),
    .mprf_rd_data_o   (mprf_rd_data_o),
    .outst_cnt_o      (outst_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    exu_wr_req_i     = 1'b0;
    exu_wr_addr_i    = 5'd0;
    exu_wr_data_i    = 32'd0;
    lsu_issue_vld_i  = 1'b0;
    lsu_issue_addr_i = 5'd0;
    lsu_wr_vld_i     = 1'b0;
    lsu_wr_addr_i    = 5'd0;
    lsu_wr_data_i    = 32'd0;
    rs1_addr_i       = 5'd0;
    rs2_addr_i       = 5'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    exu_wr_req_i  = 1'b1;
    exu_wr_addr_i = 5'd7;
    lsu_wr_vld_i  = 1'b1;
    #2;
    checks++;
    if (exu_wr_rdy_o !== 1'b0) begin errs++; $display("FAIL reset_exu_rdy got=%0b exp=0", exu_wr_rdy_o); end
    checks++;
    if (lsu_wr_rdy_o !== 1'b0) begin errs++; $display("FAIL reset_lsu_rdy got=%0b exp=0", lsu_wr_rdy_o); end
    clear_inputs();
    rst_n = 1'b1;
    next_cycle();
    // build state: busy[5], outst=1
    lsu_issue_vld_i  = 1'b1;
    lsu_issue_addr_i = 5'd5;
    next_cycle();
    clear_inputs();
    rs1_addr_i = 5'd5;
    #1;
    checks++;
    if (rs1_busy_o !== 1'b1 || outst_cnt_o !== 3'd1) begin
      errs++; $display("FAIL pre_reset_state busy=%0b cnt=%0d exp busy=1 cnt=1", rs1_busy_o, outst_cnt_o);
    end
    exu_wr_req_i     = 1'b1;
    exu_wr_addr_i    = 5'd7;
    lsu_issue_vld_i  = 1'b1;
    lsu_issue_addr_i = 5'd6;
    lsu_wr_vld_i     = 1'b1;
    lsu_wr_addr_i    = 5'd5;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rs1_busy_o !== 1'b0 || outst_cnt_o !== 3'd0) begin
      errs++; $display("FAIL async_reset_state busy=%0b cnt=%0d exp 0 0", rs1_busy_o, outst_cnt_o);
    end
    checks++;
    if ({exu_wr_rdy_o, lsu_wr_rdy_o, lsu_issue_rdy_o, mprf_w_req_o} !== 4'b0000) begin
      errs++; $display("FAIL async_reset_outs got=%b exp=0000",
                       {exu_wr_rdy_o, lsu_wr_rdy_o, lsu_issue_rdy_o, mprf_w_req_o});
    end
    clear_inputs();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_load_roundtrip();
    clear_inputs();
    lsu_issue_vld_i  = 1'b1;
    lsu_issue_addr_i = 5'd5;
    #1;
    checks++;
    if (lsu_issue_rdy_o !== 1'b1) begin errs++; $display("FAIL rt_issue_rdy got=%0b exp=1", lsu_issue_rdy_o); end
    next_cycle();
    clear_inputs();
    rs1_addr_i = 5'd5;
    rs2_addr_i = 5'd6;
    #1;
    checks++;
    if (rs1_busy_o !== 1'b1 || rs2_busy_o !== 1'b0) begin
      errs++; $display("FAIL rt_rs_busy got rs1=%0b rs2=%0b exp 1 0", rs1_busy_o, rs2_busy_o);
    end
    lsu_wr_vld_i  = 1'b1;
    lsu_wr_addr_i = 5'd5;
    lsu_wr_data_i = 32'hDEADBEEF;
    #1;
    checks++;
    if (mprf_w_req_o !== 1'b1 || mprf_rd_addr_o !== 5'd5 || mprf_rd_data_o !== 32'hDEADBEEF || lsu_wr_rdy_o !== 1'b1) begin
      errs++; $display("FAIL rt_return got req=%0b addr=%0d data=%h rdy=%0b exp 1 5 deadbeef 1",
                       mprf_w_req_o, mprf_rd_addr_o, mprf_rd_data_o, lsu_wr_rdy_o);
    end
    checks++;
    if (rs1_busy_o !== 1'b1 || outst_cnt_o !== 3'd1) begin
      errs++; $display("FAIL rt_no_early_clear busy=%0b cnt=%0d exp 1 1", rs1_busy_o, outst_cnt_o);
    end
    next_cycle();
    lsu_wr_vld_i = 1'b0;
    #1;
    checks++;
    if (rs1_busy_o !== 1'b0 || outst_cnt_o !== 3'd0 || mprf_w_req_o !== 1'b0) begin
      errs++; $display("FAIL rt_after busy=%0b cnt=%0d req=%0b exp 0 0 0", rs1_busy_o, outst_cnt_o, mprf_w_req_o);
    end
  endtask

  task automatic test_starvation();
    clear_inputs();
    lsu_issue_vld_i  = 1'b1;
    lsu_issue_addr_i = 5'd3;
    next_cycle();
    clear_inputs();
    exu_wr_req_i  = 1'b1;
    exu_wr_addr_i = 5'd7;
    exu_wr_data_i = 32'h0000_0077;
    lsu_wr_vld_i  = 1'b1;
    lsu_wr_addr_i = 5'd3;
    lsu_wr_data_i = 32'h0000_0033;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (c < 3) begin
        if (exu_wr_rdy_o !== 1'b1 || lsu_wr_rdy_o !== 1'b0 || mprf_rd_addr_o !== 5'd7) begin
          errs++; $display("FAIL starve_exu_cycle%0d exu=%0b lsu=%0b addr=%0d exp 1 0 7",
                           c, exu_wr_rdy_o, lsu_wr_rdy_o, mprf_rd_addr_o);
        end
      end else begin
        if (exu_wr_rdy_o !== 1'b0 || lsu_wr_rdy_o !== 1'b1 || mprf_rd_addr_o !== 5'd3 || mprf_rd_data_o !== 32'h0000_0033) begin
          errs++; $display("FAIL starve_lsu_cycle%0d exu=%0b lsu=%0b addr=%0d data=%h exp 0 1 3 00000033",
                           c, exu_wr_rdy_o, lsu_wr_rdy_o, mprf_rd_addr_o, mprf_rd_data_o);
        end
      end
      next_cycle();
    end
    // wait counter restarted: EXU wins again with LSU still valid
    #1;
    checks++;
    if (exu_wr_rdy_o !== 1'b1 || lsu_wr_rdy_o !== 1'b0 || outst_cnt_o !== 3'd0) begin
      errs++; $display("FAIL starve_wait_cleared exu=%0b lsu=%0b cnt=%0d exp 1 0 0",
                       exu_wr_rdy_o, lsu_wr_rdy_o, outst_cnt_o);
    end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_waw_stall();
    clear_inputs();
    lsu_issue_vld_i  = 1'b1;
    lsu_issue_addr_i = 5'd9;
    next_cycle();
    clear_inputs();
    exu_wr_req_i  = 1'b1;
    exu_wr_addr_i = 5'd9;
    exu_wr_data_i = 32'h1234_5678;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (exu_wr_rdy_o !== 1'b0 || mprf_w_req_o !== 1'b0) begin
        errs++; $display("FAIL waw_stall_cycle%0d rdy=%0b req=%0b exp 0 0", c, exu_wr_rdy_o, mprf_w_req_o);
      end
      next_cycle();
    end
    lsu_wr_vld_i  = 1'b1;
    lsu_wr_addr_i = 5'd9;
    lsu_wr_data_i = 32'hAAAA_0009;
    #1;
    checks++;
    if (exu_wr_rdy_o !== 1'b0 || lsu_wr_rdy_o !== 1'b1 || mprf_rd_data_o !== 32'hAAAA_0009) begin
      errs++; $display("FAIL waw_lsu_return exu=%0b lsu=%0b data=%h exp 0 1 aaaa0009",
                       exu_wr_rdy_o, lsu_wr_rdy_o, mprf_rd_data_o);
    end
    next_cycle();
    lsu_wr_vld_i = 1'b0;
    #1;
    checks++;
    if (exu_wr_rdy_o !== 1'b1 || mprf_w_req_o !== 1'b1 || mprf_rd_addr_o !== 5'd9 || mprf_rd_data_o !== 32'h1234_5678) begin
      errs++; $display("FAIL waw_exu_after exu=%0b req=%0b addr=%0d data=%h exp 1 1 9 12345678",
                       exu_wr_rdy_o, mprf_w_req_o, mprf_rd_addr_o, mprf_rd_data_o);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_credit_limit();
    clear_inputs();
    lsu_issue_vld_i  = 1'b1;
    lsu_issue_addr_i = 5'd1;
    next_cycle();
    lsu_issue_addr_i = 5'd2;
    #1;
    checks++;
    if (lsu_issue_rdy_o !== 1'b1) begin errs++; $display("FAIL credit_second_issue got=%0b exp=1", lsu_issue_rdy_o); end
    next_cycle();
    lsu_issue_addr_i = 5'd4;
    #1;
    checks++;
    if (lsu_issue_rdy_o !== 1'b0 || outst_cnt_o !== 3'd2) begin
      errs++; $display("FAIL credit_full rdy=%0b cnt=%0d exp 0 2", lsu_issue_rdy_o, outst_cnt_o);
    end
    lsu_wr_vld_i  = 1'b1;
    lsu_wr_addr_i = 5'd1;
    #1;
    checks++;
    if (lsu_issue_rdy_o !== 1'b0 || lsu_wr_rdy_o !== 1'b1) begin
      errs++; $display("FAIL credit_same_cycle issue_rdy=%0b ret_rdy=%0b exp 0 1", lsu_issue_rdy_o, lsu_wr_rdy_o);
    end
    next_cycle();
    lsu_wr_vld_i = 1'b0;
    #1;
    checks++;
    if (lsu_issue_rdy_o !== 1'b1 || outst_cnt_o !== 3'd1) begin
      errs++; $display("FAIL credit_freed rdy=%0b cnt=%0d exp 1 1", lsu_issue_rdy_o, outst_cnt_o);
    end
    next_cycle();
    clear_inputs();
    #1;
    checks++;
    if (outst_cnt_o !== 3'd2) begin errs++; $display("FAIL credit_refill cnt=%0d exp 2", outst_cnt_o); end
    lsu_wr_vld_i  = 1'b1;
    lsu_wr_addr_i = 5'd2;
    next_cycle();
    lsu_wr_addr_i = 5'd4;
    next_cycle();
    clear_inputs();
    #1;
    checks++;
    if (outst_cnt_o !== 3'd0) begin errs++; $display("FAIL credit_drain cnt=%0d exp 0", outst_cnt_o); end
  endtask

  task automatic test_x0();
    clear_inputs();
    exu_wr_req_i     = 1'b1;
    exu_wr_addr_i    = 5'd0;
    exu_wr_data_i    = 32'hFFFF_FFFF;
    lsu_issue_vld_i  = 1'b1;
    lsu_issue_addr_i = 5'd0;
    #1;
    checks++;
    if (exu_wr_rdy_o !== 1'b1 || mprf_w_req_o !== 1'b0 || lsu_issue_rdy_o !== 1'b1) begin
      errs++; $display("FAIL x0_write exu=%0b req=%0b issue=%0b exp 1 0 1", exu_wr_rdy_o, mprf_w_req_o, lsu_issue_rdy_o);
    end
    next_cycle();
    clear_inputs();
    #1;
    checks++;
    if (rs1_busy_o !== 1'b0 || outst_cnt_o !== 3'd1) begin
      errs++; $display("FAIL x0_issue busy=%0b cnt=%0d exp 0 1", rs1_busy_o, outst_cnt_o);
    end
    lsu_wr_vld_i = 1'b1;
    #1;
    checks++;
    if (lsu_wr_rdy_o !== 1'b1 || mprf_w_req_o !== 1'b0) begin
      errs++; $display("FAIL x0_return rdy=%0b req=%0b exp 1 0", lsu_wr_rdy_o, mprf_w_req_o);
    end
    next_cycle();
    clear_inputs();
    #1;
    checks++;
    if (outst_cnt_o !== 3'd0) begin errs++; $display("FAIL x0_drain cnt=%0d exp 0", outst_cnt_o); end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    #12;
    test_reset();
    test_load_roundtrip();
    test_starvation();
    test_waw_stall();
    test_credit_limit();
    test_x0();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ycr1_pipe_mprf_wrctl.md
Name: ycr1_pipe_mprf_wrctl

Overview:
MPRF write-port controller and register scoreboard. It shares the single MPRF write port between two requesters:
- EXU single-cycle writeback;
- LSU load-return writeback, which is multi-cycle and can arrive out of step with the EXU.

It tracks destination registers of outstanding loads, stalls dependent reads and WAW writes, and bounds LSU starvation. It sits between the EXU/LSU and the MPRF write/read-address interface.

Parameters:
- AWIDTH, 5, MPRF address width; x0 is never written and never busy.
- XLEN, 32, data width.
- MAX_OUTST, 2, maximum outstanding loads, range 1..7.
- MAX_WAIT, 3, consecutive LSU-lost cycles before LSU is forced to priority, range 1..15.

Ports:
- clk  in  1  MPRF clock
- rst_n  in  1  asynchronous active-low reset
- exu_wr_req_i  in  1  EXU writeback request
- exu_wr_addr_i  in  AWIDTH  EXU rd address
- exu_wr_data_i  in  XLEN  EXU rd data
- exu_wr_rdy_o  out  1  EXU write accepted this cycle
- lsu_issue_vld_i  in  1  load issue with destination rd
- lsu_issue_addr_i  in  AWIDTH  load destination rd
- lsu_issue_rdy_o  out  1  load issue accepted
- lsu_wr_vld_i  in  1  load data return
- lsu_wr_addr_i  in  AWIDTH  load return rd
- lsu_wr_data_i  in  XLEN  load return data
- lsu_wr_rdy_o  out  1  load return accepted
- rs1_addr_i  in  AWIDTH  rs1 address, passed through to the MPRF
- rs2_addr_i  in  AWIDTH  rs2 address, passed through to the MPRF
- rs1_busy_o  out  1  rs1 has a pending load
- rs2_busy_o  out  1  rs2 has a pending load
- mprf_w_req_o  out  1  MPRF write request
- mprf_rd_addr_o  out  AWIDTH  MPRF write address
- mprf_rd_data_o  out  XLEN  MPRF write data
- outst_cnt_o  out  3  outstanding-load count (debug)

Behaviour:

State
- busy[2^AWIDTH-1:1] scoreboard bits.
- outst_cnt, 3 bits.
- wait_cnt, 4 bits.
- Reset (async, rst_n=0) clears all state to 0. While rst_n=0 every rdy output and mprf_w_req_o is forced to 0.

Arbitration (combinational, zero latency)
- LSU priority is asserted when wait_cnt == MAX_WAIT.
- Without LSU priority: EXU wins over LSU.
- With LSU priority: LSU wins; EXU sees exu_wr_rdy_o=0.
- EXU eligibility: exu_wr_req_i and not busy[exu_wr_addr_i]. This is the WAW stall. Address 0 is always eligible.
- EXU write to x0: exu_wr_rdy_o=1 and it consumes the port slot, but mprf_w_req_o=0.
- LSU return is always eligible. Its address is expected busy; an LSU return to a non-busy rd is still written and no bit is changed.
- Granted request drives mprf_rd_addr_o and mprf_rd_data_o. mprf_w_req_o = grant & (addr != 0).
- No grant: mprf_w_req_o=0; addr/data outputs are 0.
- At most one of exu_wr_rdy_o and lsu_wr_rdy_o is high in any cycle.

Starvation counter
- Increments (saturating at MAX_WAIT) when lsu_wr_vld_i=1 and lsu_wr_rdy_o=0.
- Clears on any LSU grant, and when lsu_wr_vld_i=0.

Scoreboard
- lsu_issue_rdy_o = (outst_cnt < MAX_OUTST) & !busy[lsu_issue_addr_i]. Address 0 is never busy.
- Issue to an rd being cleared in the same cycle is stalled, because busy is still 1.
- Issue to an rd the EXU writes in the same cycle is allowed; the EXU write lands first.
- Accepted issue with rd != 0: busy[rd] is set at the next edge.
- Accepted issue with rd == 0: busy is unchanged, but outst_cnt still increments.
- LSU grant: busy[lsu_wr_addr_i] is cleared and outst_cnt decrements.
- Simultaneous issue and return: outst_cnt is unchanged; the set and clear apply to different bits.
- outst_cnt_o reflects the registered count; a return does not free a credit in the same cycle.

Hazard outputs (combinational)
- rs1_busy_o = busy[rs1_addr_i], 0 for x0. rs2_busy_o likewise.
- Busy clears one cycle after the return write. No forwarding; the MPRF bypass handles the write/read collision.

Test Plan:
1. Reset mid-operation: set busy[5] and outst_cnt=1, assert rst_n=0 asynchronously → busy, counters and all rdy/w_req outputs read 0 immediately.
2. Load issue rd=5, then rs1_addr=5 → rs1_busy_o=1. LSU return rd=5 data 0xDEADBEEF → mprf_w_req_o=1, addr 5, data 0xDEADBEEF; next cycle rs1_busy_o=0 and outst_cnt_o=0.
3. EXU writes rd=7 continuously while LSU holds return valid (rd=3) → EXU granted 3 cycles, LSU granted on the 4th cycle, EXU rdy=0 that cycle, wait_cnt cleared.
4. Busy[9] pending, EXU write rd=9 → exu_wr_rdy_o=0 until the LSU return for rd=9 is accepted; the EXU is granted in the following cycle.
5. MAX_OUTST=2: issue rd=1 and rd=2, then a third issue rd=4 → lsu_issue_rdy_o=0. Same-cycle return of rd=1 and issue rd=4 → still 0; issue is accepted the next cycle.
6. EXU write rd=0 and load issue rd=0 → exu_wr_rdy_o=1, mprf_w_req_o=0, rs1_busy_o for x0 stays 0, outst_cnt_o=1.
